// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM states, client ids
// and SRAM byte-enable patterns.
package mem_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'b001,
      ST_ACCESS  = 3'b010,
      ST_RECOVER = 3'b100
   } state_t;

   typedef enum logic [1:0] {
      CL_NONE  = 2'd0,
      CL_FETCH = 2'd1,
      CL_LD    = 2'd2,
      CL_ST    = 2'd3
   } client_t;

   localparam logic [1:0] BE_WORD = 2'b11;
   localparam logic [1:0] BE_HI   = 2'b10;
   localparam logic [1:0] BE_LO   = 2'b01;

   // Big-endian: even byte address lives in the upper half of the word.
   function automatic logic [1:0] store_be(input logic is_byte,
                                           input logic a0);
      if (!is_byte)
         return BE_WORD;
      return a0 ? BE_LO : BE_HI;
   endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// 4-bit load/decrement counter with a zero flag, used to
// stretch an SRAM access by the configured wait states.
module mem_wait_counter (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load,
   input  logic       dec,
   input  logic [3:0] din,
   output logic [3:0] cnt,
   output logic       zero
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cnt <= 4'd0;
      else if (load)
         cnt <= din;
      else if (dec && cnt != 4'd0)
         cnt <= cnt - 4'd1;
   end

   assign zero = (cnt == 4'd0);

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority (store > load > fetch) arbiter onto one
// 16-bit synchronous SRAM port with programmable wait states.
module mem_arbiter #(
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        fetch_req,
   input  logic [15:0] fetch_addr,
   output logic        fetch_done,
   input  logic        ld_req,
   input  logic [15:0] ld_addr,
   output logic        ld_done,
   input  logic        st_req,
   input  logic [15:0] st_addr,
   input  logic [15:0] st_data,
   input  logic        st_byte,
   output logic        st_done,
   output logic [15:0] rd_data,
   output logic [14:0] sram_addr,
   output logic [15:0] sram_wdata,
   output logic [1:0]  sram_be,
   output logic        sram_ce,
   output logic        sram_we,
   input  logic [15:0] sram_rdata
);

   import mem_arbiter_pkg::*;

   localparam logic [3:0] WS = 4'(WAIT_STATES);

   state_t      state;
   state_t      state_nx;
   client_t     grant;
   client_t     owner;
   logic [14:0] g_addr;
   logic [15:0] g_wdata;
   logic [1:0]  g_be;
   logic        load;
   logic        dec;
   logic        fin;
   logic        zero;
   logic [3:0]  cnt;

   // Reads fetch whole words; the byte select is the client's job.
   logic unused_bits;
   assign unused_bits = ^{fetch_addr[0], ld_addr[0], cnt};

   always_comb begin
      grant   = CL_NONE;
      g_addr  = '0;
      g_wdata = '0;
      g_be    = BE_WORD;
      priority case (1'b1)
         st_req: begin
            grant   = CL_ST;
            g_addr  = st_addr[15:1];
            g_wdata = st_byte ? {st_data[7:0], st_data[7:0]}
                              : st_data;
            g_be    = store_be(st_byte, st_addr[0]);
         end
         ld_req: begin
            grant  = CL_LD;
            g_addr = ld_addr[15:1];
         end
         fetch_req: begin
            grant  = CL_FETCH;
            g_addr = fetch_addr[15:1];
         end
         default: grant = CL_NONE;
      endcase
   end

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      dec      = 1'b0;
      fin      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (grant != CL_NONE) begin
               load     = 1'b1;
               state_nx = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (zero) begin
               fin      = 1'b1;
               state_nx = ST_RECOVER;
            end else begin
               dec = 1'b1;
            end
         end
         // Requests are stale here: the client is still dropping its own.
         ST_RECOVER: state_nx = ST_IDLE;
         default:    state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   mem_wait_counter u_wait (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (load),
      .dec     (dec),
      .din     (WS),
      .cnt     (cnt),
      .zero    (zero)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         owner      <= CL_NONE;
         sram_addr  <= '0;
         sram_wdata <= '0;
         sram_be    <= '0;
         sram_ce    <= 1'b0;
         sram_we    <= 1'b0;
         rd_data    <= '0;
         fetch_done <= 1'b0;
         ld_done    <= 1'b0;
         st_done    <= 1'b0;
      end else begin
         fetch_done <= 1'b0;
         ld_done    <= 1'b0;
         st_done    <= 1'b0;
         if (load) begin
            owner      <= grant;
            sram_addr  <= g_addr;
            sram_wdata <= g_wdata;
            sram_be    <= g_be;
            sram_ce    <= 1'b1;
            sram_we    <= (grant == CL_ST);
         end else if (fin) begin
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_be    <= '0;
            sram_ce    <= 1'b0;
            sram_we    <= 1'b0;
            if (owner != CL_ST)
               rd_data <= sram_rdata;
            fetch_done <= (owner == CL_FETCH);
            ld_done    <= (owner == CL_LD);
            st_done    <= (owner == CL_ST);
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with one wait
// state, one with none, scoreboard of expected completions.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        fetch_req, ld_req, st_req, st_byte;
   logic [15:0] fetch_addr, ld_addr, st_addr, st_data;

   logic        u1_fd, u1_ld, u1_sd, u1_ce, u1_we;
   logic [15:0] u1_rd, u1_wd, u1_rdata;
   logic [14:0] u1_addr;
   logic [1:0]  u1_be;

   logic        u0_fd, u0_ld, u0_sd, u0_ce, u0_we;
   logic [15:0] u0_rd, u0_wd, u0_rdata;
   logic [14:0] u0_addr;
   logic [1:0]  u0_be;

   always #5 clk = ~clk;

   function automatic logic [15:0] rd_model(input logic [14:0] wa);
      if (wa == 15'h091A)
         return 16'hBEEF;
      return {wa, 1'b1} ^ 16'h6C3A;
   endfunction

   assign u1_rdata = (u1_ce && !u1_we) ? rd_model(u1_addr) : 16'h0;
   assign u0_rdata = (u0_ce && !u0_we) ? rd_model(u0_addr) : 16'h0;

   mem_arbiter #(.WAIT_STATES(1)) u1 (
      .clk(clk), .reset_n(reset_n),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_done(u1_fd),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_done(u1_ld),
      .st_req(st_req), .st_addr(st_addr), .st_data(st_data),
      .st_byte(st_byte), .st_done(u1_sd), .rd_data(u1_rd),
      .sram_addr(u1_addr), .sram_wdata(u1_wd), .sram_be(u1_be),
      .sram_ce(u1_ce), .sram_we(u1_we), .sram_rdata(u1_rdata)
   );

   mem_arbiter #(.WAIT_STATES(0)) u0 (
      .clk(clk), .reset_n(reset_n),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_done(u0_fd),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_done(u0_ld),
      .st_req(st_req), .st_addr(st_addr), .st_data(st_data),
      .st_byte(st_byte), .st_done(u0_sd), .rd_data(u0_rd),
      .sram_addr(u0_addr), .sram_wdata(u0_wd), .sram_be(u0_be),
      .sram_ce(u0_ce), .sram_we(u0_we), .sram_rdata(u0_rdata)
   );

   logic        sel = 1'b0;
   logic [2:0]  o_done;
   logic [15:0] o_rd, o_wd;
   logic [14:0] o_addr;
   logic [1:0]  o_be;
   logic        o_ce, o_we;

   assign o_done = sel ? {u0_sd, u0_ld, u0_fd} : {u1_sd, u1_ld, u1_fd};
   assign o_rd   = sel ? u0_rd : u1_rd;
   assign o_wd   = sel ? u0_wd : u1_wd;
   assign o_addr = sel ? u0_addr : u1_addr;
   assign o_be   = sel ? u0_be : u1_be;
   assign o_ce   = sel ? u0_ce : u1_ce;
   assign o_we   = sel ? u0_we : u1_we;

   typedef struct {
      logic [2:0]  done;
      logic        is_rd;
      logic [15:0] rd;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   logic [14:0] x_addr;
   logic [15:0] x_wd, last_rd;
   logic [1:0]  x_be;
   logic        x_we;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int cl, input logic [15:0] a,
                        input logic [15:0] d, input logic b);
      exp_t e;
      case (cl)
         0: begin fetch_req = 1'b1; fetch_addr = a; end
         1: begin ld_req = 1'b1; ld_addr = a; end
         default: begin
            st_req = 1'b1; st_addr = a; st_data = d; st_byte = b;
         end
      endcase
      e.done  = 3'b001 << cl;
      e.is_rd = (cl != 2);
      e.rd    = rd_model(a[15:1]);
      sb.push_back(e);
      x_addr = a[15:1];
      x_we   = (cl == 2);
      x_be   = (cl == 2 && b) ? (a[0] ? 2'b01 : 2'b10) : 2'b11;
      x_wd   = b ? {d[7:0], d[7:0]} : d;
   endtask

   task automatic drop(input logic [2:0] m);
      if (m[0]) fetch_req = 1'b0;
      if (m[1]) ld_req = 1'b0;
      if (m[2]) st_req = 1'b0;
   endtask

   // Waits for ndone completions; the client drops (or re-requests
   // with the next address when keep) on the edge after its done.
   task automatic run(input int ndone, input int first, input int period,
                      input bit strobes, input bit keep);
      int n, got, prev;
      logic [2:0] pend;
      exp_t e;
      n = 0; got = 0; prev = -1; pend = '0;
      while (got < ndone && n < 60) begin
         tick();
         n++;
         if (pend != 0) begin
            chk("recover_no_done", {29'd0, o_done}, 0);
            if (keep && got < ndone)
               issue(0, fetch_addr + 16'd2, 16'd0, 1'b0);
            else
               drop(pend);
            pend = '0;
         end
         if (o_done != 0) begin
            chk("done_onehot", 32'($onehot(o_done)), 1);
            if (sb.size() == 0) begin
               chk("unexpected_done", {29'd0, o_done}, 0);
            end else begin
               e = sb.pop_front();
               chk("done_client", {29'd0, o_done}, {29'd0, e.done});
               if (e.is_rd) last_rd = e.rd;
               chk("rd_data", {16'd0, o_rd}, {16'd0, last_rd});
            end
            chk("strobes_off", {28'd0, o_ce, o_we, o_be}, 0);
            if (prev < 0)
               chk("latency", n, first);
            else
               chk("period", n - prev, period);
            prev = n;
            pend = o_done;
            got++;
         end else if (strobes && got == 0) begin
            chk("ce", {31'd0, o_ce}, 1);
            chk("we", {31'd0, o_we}, {31'd0, x_we});
            chk("be", {30'd0, o_be}, {30'd0, x_be});
            chk("addr", {17'd0, o_addr}, {17'd0, x_addr});
            if (x_we) chk("wdata", {16'd0, o_wd}, {16'd0, x_wd});
         end
      end
      if (got < ndone) chk("done_timeout", got, ndone);
      if (pend != 0) begin
         tick();
         chk("recover_no_done", {29'd0, o_done}, 0);
         drop(pend);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      fetch_req = 0; ld_req = 0; st_req = 0; st_byte = 0;
      fetch_addr = 0; ld_addr = 0; st_addr = 0; st_data = 0;
      last_rd = 0; x_addr = 0; x_wd = 0; x_be = 0; x_we = 0;
      tick();
      tick();
      chk("rst_ctl", {25'd0, u1_ce, u1_we, u1_be, u1_fd, u1_ld, u1_sd}, 0);
      chk("rst_addr_wd", {u1_addr, 1'b0, u1_wd}, 0);
      chk("rst_rd", {16'd0, u1_rd}, 0);
      chk("rst_u0", {u0_ce, u0_we, u0_be, u0_addr, u0_rd[12:0]}, 0);
      reset_n = 1'b1;
      tick();

      // reset in the middle of a store
      issue(2, 16'h0040, 16'h1234, 1'b0);
      tick();
      chk("mid_ce_we", {30'd0, u1_ce, u1_we}, 3);
      #2 reset_n = 1'b0;
      #1 chk("rst_drop_ce_we", {30'd0, u1_ce, u1_we}, 0);
      void'(sb.pop_back());
      st_req = 1'b0;
      tick();
      chk("rst_no_done", {29'd0, o_done}, 0);
      reset_n = 1'b1;
      tick();
      tick();
      chk("post_rst_idle", {20'd0, u1_ce, u1_we, u1_be, o_done, u1_rd[5:0]}, 0);
      last_rd = 16'h0;

      // load with one wait state, then stale request check
      issue(1, 16'h1235, 16'h0, 1'b0);
      run(1, 3, 0, 1'b1, 1'b0);
      chk("beef", {16'd0, u1_rd}, 32'h0000BEEF);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("stale_no_access", {28'd0, u1_ce, o_done}, 0);
      end

      // byte stores at both byte lanes, word store, fetch
      issue(2, 16'h0010, 16'h00A5, 1'b1);
      run(1, 3, 0, 1'b1, 1'b0);
      tick();
      issue(2, 16'h0011, 16'h3C5A, 1'b1);
      run(1, 3, 0, 1'b1, 1'b0);
      tick();
      issue(2, 16'h0021, 16'hCAFE, 1'b0);
      run(1, 3, 0, 1'b1, 1'b0);
      tick();
      issue(0, 16'h7FFE, 16'h0, 1'b0);
      run(1, 3, 0, 1'b1, 1'b0);
      tick();

      // all three at once: st, ld, fetch order
      issue(2, 16'h0300, 16'h5555, 1'b0);
      issue(1, 16'h0202, 16'h0, 1'b0);
      issue(0, 16'h0100, 16'h0, 1'b0);
      run(3, 3, 4, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) tick();

      // no wait states, continuous fetch
      sel = 1'b1;
      issue(0, 16'h0400, 16'h0, 1'b0);
      run(5, 2, 3, 1'b1, 1'b1);
      tick();
      chk("final_idle", {28'd0, u0_ce, o_done}, 0);

      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
